// File: rtl/ssd_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared decoder across DIGITS common-anode
// digits, with a blanking gap between digits and frame-aligned double-buffered updates.
module ssd_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      load,
    input  logic [4*DIGITS-1:0]       value,
    input  logic [DIGITS-1:0]         blank_mask,
    output logic [3:0]                nibble,
    output logic [DIGITS-1:0]         anode,
    output logic [$clog2(DIGITS)-1:0] digit_idx,
    output logic                      frame_done
);

    localparam int IW   = $clog2(DIGITS);
    localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [4*DIGITS-1:0] shadow, shadow_nxt;
    logic [4*DIGITS-1:0] pending, pending_nxt;
    logic                pending_vld, pending_vld_nxt;
    logic                wrap;
    logic [3:0]          nibble_nxt;
    logic [DIGITS-1:0]   anode_nxt;

    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        cnt_nxt         = cnt;
        shadow_nxt      = shadow;
        pending_nxt     = pending;
        pending_vld_nxt = pending_vld;
        wrap            = 1'b0;

        if (!en) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
                BLANK: begin
                    if (cnt == CW'(BLANK_CYCLES - 1)) begin
                        state_nxt = SHOW;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                SHOW: begin
                    if (cnt == CW'(REFRESH_DIV - 1)) begin
                        state_nxt = BLANK;
                        cnt_nxt   = '0;
                        if (idx == IW'(DIGITS - 1)) begin
                            idx_nxt = '0;
                            wrap    = 1'b1;
                        end else begin
                            idx_nxt = idx + IW'(1);
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // A load that coincides with the wrap beats any older pending value.
        if (state == IDLE) begin
            if (load) begin
                shadow_nxt      = value;
                pending_vld_nxt = 1'b0;
            end
        end else if (wrap) begin
            if (load) begin
                shadow_nxt = value;
            end else if (pending_vld) begin
                shadow_nxt = pending;
            end
            pending_vld_nxt = 1'b0;
        end else if (load) begin
            pending_nxt     = value;
            pending_vld_nxt = 1'b1;
        end

        // Outputs are registered from next-state so anodes follow state on the same edge.
        nibble_nxt = 4'h0;
        anode_nxt  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_nxt == IW'(i)) begin
                nibble_nxt = shadow_nxt[4*i +: 4];
                if (state_nxt == SHOW && !blank_mask[i]) begin
                    anode_nxt[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            shadow      <= '0;
            pending     <= '0;
            pending_vld <= 1'b0;
            nibble      <= 4'h0;
            anode       <= '1;
            digit_idx   <= '0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            cnt         <= cnt_nxt;
            shadow      <= shadow_nxt;
            pending     <= pending_nxt;
            pending_vld <= pending_vld_nxt;
            nibble      <= nibble_nxt;
            anode       <= anode_nxt;
            digit_idx   <= idx_nxt;
            frame_done  <= wrap;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl (DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2):
// stimulus pushes the expected per-cycle display state, a monitor pops and compares.
module tb_ssd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic [3:0]  nibble;
    logic [3:0]  anode;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] anode;
        logic [3:0] nib;
        bit         nib_care;
        logic [1:0] idx;
        logic       fd;
        int         tag;
    } exp_t;

    exp_t sb[$];

    ssd_scan_ctrl #(
        .DIGITS      (4),
        .REFRESH_DIV (4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .value     (value),
        .blank_mask(blank_mask),
        .nibble    (nibble),
        .anode     (anode),
        .digit_idx (digit_idx),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, pending=%0d", sb.size());
        $fatal(1, "watchdog expired");
    end

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            checks++;
            if (anode !== x.anode || digit_idx !== x.idx || frame_done !== x.fd ||
                (x.nib_care && nibble !== x.nib)) begin
                failures++;
                $display("FAIL scan tag=%0d: got anode=%b nibble=%h idx=%0d fd=%b, want anode=%b nibble=%h(care=%0d) idx=%0d fd=%b",
                         x.tag, anode, nibble, digit_idx, frame_done,
                         x.anode, x.nib, x.nib_care, x.idx, x.fd);
            end
        end
    end

    task automatic direct_check(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_reset_outputs(input string where);
        direct_check({where, "_anode"}, anode, 4'b1111);
        direct_check({where, "_nibble"}, nibble, 4'h0);
        direct_check({where, "_idx"}, {2'b00, digit_idx}, 4'h0);
        direct_check({where, "_fd"}, {3'b000, frame_done}, 4'h0);
    endtask

    task automatic step(input logic e, input logic ld, input logic [15:0] v,
                        input logic [3:0] m, input exp_t x);
        @(negedge clk);
        en = e;
        load = ld;
        value = v;
        blank_mask = m;
        sb.push_back(x);
    endtask

    // Expected state for cycle p (0..23) of a frame: 2 blank then 4 lit cycles per digit.
    function automatic exp_t frame_exp(input logic [15:0] shown, input logic [3:0] m,
                                       input int p, input bit fd_first, input int tag);
        exp_t x;
        int d;
        d = p / 6;
        x.anode = 4'b1111;
        if ((p % 6) >= 2 && !m[d]) x.anode[d] = 1'b0;
        x.nib = shown[4*d +: 4];
        x.nib_care = 1'b1;
        x.idx = 2'(d);
        x.fd = (fd_first && p == 0);
        x.tag = tag;
        return x;
    endfunction

    function automatic exp_t idle_exp(input int tag);
        exp_t x;
        x.anode = 4'b1111;
        x.nib = 4'h0;
        x.nib_care = 1'b0;
        x.idx = 2'd0;
        x.fd = 1'b0;
        x.tag = tag;
        return x;
    endfunction

    task automatic run_frame(input logic [15:0] shown, input logic [3:0] m, input bit fd_first,
                             input int ld_p, input logic [15:0] ld_val, input int stop_p,
                             input int tag);
        for (int p = 0; p < stop_p; p++) begin
            step(1'b1, (p == ld_p), (p == ld_p) ? ld_val : 16'h0, m,
                 frame_exp(shown, m, p, fd_first, tag * 100 + p));
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("reset_init");
        @(negedge clk);
        rst_n = 1'b1;

        // Load in IDLE then scan 1234 for two frames; deferred ABCD loaded in digit 1
        step(1'b0, 1'b1, 16'h1234, 4'h0, idle_exp(1));
        run_frame(16'h1234, 4'h0, 1'b0, -1, 16'h0, 24, 2);
        run_frame(16'h1234, 4'h0, 1'b1, 8, 16'hABCD, 24, 3);
        // ABCD appears from the wrap; pending 5555 queued mid-frame
        run_frame(16'hABCD, 4'h0, 1'b1, 10, 16'h5555, 24, 4);
        // 0F0F loaded on the wrap edge overrides 5555
        run_frame(16'h0F0F, 4'h0, 1'b1, 0, 16'h0F0F, 24, 5);
        // Digit 2 masked; en dropped during digit 3
        run_frame(16'h0F0F, 4'b0100, 1'b1, -1, 16'h0, 21, 6);
        step(1'b0, 1'b0, 16'h0, 4'b0100, idle_exp(7));
        step(1'b0, 1'b0, 16'h0, 4'b0100, idle_exp(8));
        // Restart at digit 0 BLANK with no frame pulse
        run_frame(16'h0F0F, 4'h0, 1'b0, -1, 16'h0, 24, 9);
        // Next frame: queue 1111, then reset mid-SHOW of digit 0
        run_frame(16'h0F0F, 4'h0, 1'b1, 1, 16'h1111, 3, 10);
        @(posedge clk);
        #3;
        direct_check("pre_reset_anode", anode, 4'b1110);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_show");

        // After reset the pending 1111 is gone: shadow is 0 through the next wrap
        step(1'b1, 1'b0, 16'h0, 4'h0, frame_exp(16'h0000, 4'h0, 0, 1'b0, 1100));
        rst_n = 1'b1;
        for (int p = 1; p < 24; p++) begin
            step(1'b1, 1'b0, 16'h0, 4'h0, frame_exp(16'h0000, 4'h0, p, 1'b0, 1100 + p));
        end
        run_frame(16'h0000, 4'h0, 1'b1, -1, 16'h0, 3, 12);

        // Drain with a bound
        repeat (4) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
